// File: rtl/inst_prefetch_unit.sv
`timescale 1ns/1ps
// Instruction prefetch front end: credit-limited fetch issue, in-order response queue, redirect flush.
// Optional performance counters are built only when IPU_PERF_CNT_EN is defined.
module inst_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] PC,
  output logic            Inst_Req_Valid,
  input  logic            Inst_Req_Ready,
  input  logic [XLEN-1:0] Instruction,
  input  logic            Inst_Valid,
  output logic            Inst_Ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     perf_req_cnt,
  output logic [31:0]     perf_drop_cnt,
  output logic [31:0]     perf_stall_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 2;

  logic [XLEN-1:0] r_fetch_pc, r_resp_pc, r_pc;
  logic            r_req_valid, r_req_stale;
  logic [AW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_q_count, r_outstanding, r_drop_cnt;
  logic [XLEN-1:0] r_q_pc   [DEPTH];
  logic [XLEN-1:0] r_q_inst [DEPTH];

  logic            w_hs, w_hs_fresh, w_push, w_drop, w_pop, w_pend_new, w_stale_nx;
  logic            w_issue, w_req_valid_nx;
  logic [CW-1:0]   w_q_post, w_out_post, w_drop_post, w_drop_flush;
  logic [SW-1:0]   w_sum_cur, w_sum_post, w_flush_sum;
  logic [XLEN-1:0] w_fetch_pc_nx, w_redirect_pc;

  // Post-event counts; a request pending across a redirect is tagged stale and already counted as a drop
  always_comb begin
    w_hs          = r_req_valid & Inst_Req_Ready;
    w_hs_fresh    = w_hs & ~r_req_stale;
    w_drop        = Inst_Valid & (r_drop_cnt != '0);
    w_push        = Inst_Valid & (r_drop_cnt == '0);
    w_pop         = (r_q_count != '0) & out_ready;
    w_pend_new    = r_req_valid & ~Inst_Req_Ready & ~r_req_stale;
    w_stale_nx    = r_req_valid & ~Inst_Req_Ready & (r_req_stale | redirect_valid);
    w_redirect_pc = redirect_pc & ~XLEN'(3);

    w_q_post      = r_q_count + CW'(w_push) - CW'(w_pop);
    w_out_post    = r_outstanding + CW'(w_hs_fresh) - CW'(w_push);
    w_drop_post   = r_drop_cnt - CW'(w_drop);
    w_sum_cur     = SW'(r_q_count) + SW'(r_outstanding) + SW'(r_drop_cnt);
    w_sum_post    = SW'(w_q_post) + SW'(w_out_post) + SW'(w_drop_post);
    w_flush_sum   = SW'(w_drop_post) + SW'(w_out_post) + SW'(w_pend_new);
    w_drop_flush  = CW'(w_flush_sum);

    w_fetch_pc_nx = w_hs_fresh ? (r_fetch_pc + XLEN'(4)) : r_fetch_pc;
    w_issue       = ~redirect_valid &
                    (r_req_valid ? (w_hs & (w_sum_post < SW'(DEPTH)))
                                 : (w_sum_cur < SW'(DEPTH)));
    w_req_valid_nx = (r_req_valid & ~Inst_Req_Ready) | w_issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_pc          <= RESET_PC;
      r_req_valid   <= 1'b0;
      r_req_stale   <= 1'b0;
      r_head        <= '0;
      r_tail        <= '0;
      r_q_count     <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_req_valid <= w_req_valid_nx;
      r_req_stale <= w_stale_nx;
      if (w_issue) r_pc <= w_fetch_pc_nx;
      if (redirect_valid) begin
        r_fetch_pc    <= w_redirect_pc;
        r_resp_pc     <= w_redirect_pc;
        r_outstanding <= '0;
        r_drop_cnt    <= w_drop_flush;
        r_q_count     <= '0;
        r_head        <= '0;
        r_tail        <= '0;
      end else begin
        r_fetch_pc    <= w_fetch_pc_nx;
        r_outstanding <= w_out_post;
        r_drop_cnt    <= w_drop_post;
        r_q_count     <= w_q_post;
        if (w_push) begin
          r_resp_pc <= r_resp_pc + XLEN'(4);
          r_tail    <= r_tail + AW'(1);
        end
        if (w_pop) r_head <= r_head + AW'(1);
      end
    end
  end

  // Queue storage needs no reset; occupancy is tracked by r_q_count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]   <= r_resp_pc;
      r_q_inst[r_tail] <= Instruction;
    end
  end

  assign PC             = r_pc;
  assign Inst_Req_Valid = r_req_valid;
  assign Inst_Ready     = 1'b1;
  assign out_valid      = (r_q_count != '0);
  assign out_pc         = r_q_pc[r_head];
  assign out_inst       = r_q_inst[r_head];

`ifdef IPU_PERF_CNT_EN
  logic [31:0] r_perf_req, r_perf_drop, r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_req   <= 32'd0;
      r_perf_drop  <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (w_hs) r_perf_req <= r_perf_req + 32'd1;
      if (w_drop) r_perf_drop <= r_perf_drop + 32'd1;
      if (out_ready & ~out_valid) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_req_cnt   = r_perf_req;
  assign perf_drop_cnt  = r_perf_drop;
  assign perf_stall_cnt = r_perf_stall;
`else
  assign perf_req_cnt   = 32'b0;
  assign perf_drop_cnt  = 32'b0;
  assign perf_stall_cnt = 32'b0;
`endif

endmodule
